gate_bist_checker: RTL and testbench



---
 rtl/gate_bist_checker.sv | 116 +++++++++++
 tb/tb_gate_bist_checker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gate_bist_checker.sv
// Clocked self-test engine for a 2-input gate: sweeps {b,a} exhaustively,
// samples the gate output after a settle delay and checks it against a truth table.
module gate_bist_checker #(
    parameter logic [3:0]  TRUTH_TABLE = 4'b1000,
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned LOOPS       = 1,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             o_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LOOP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t              state;
    logic [1:0]          idx;
    logic [CNT_W-1:0]    settle_cnt;
    logic [LOOP_W-1:0]   loop_cnt;
    logic                mismatch_c;
    logic [ERR_W-1:0]    err_next_c;

    // Sample result and saturating error count for the current pattern
    always_comb begin
        mismatch_c = (o_in != TRUTH_TABLE[idx]);
        err_next_c = err_count;
        if (mismatch_c && (err_count != {ERR_W{1'b1}})) begin
            err_next_c = err_count + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= 2'b00;
            settle_cnt <= '0;
            loop_cnt   <= '0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_APPLY;
                        err_count <= '0;
                        fail_vec  <= 4'b0000;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        idx       <= 2'b00;
                        loop_cnt  <= '0;
                        a_out     <= 1'b0;
                        b_out     <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    if (settle_cnt == CNT_W'(SETTLE - 1)) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    err_count <= err_next_c;
                    if (mismatch_c) begin
                        fail_vec[idx] <= 1'b1;
                    end
                    // New pattern is driven on the same edge that leaves SAMPLE
                    if (idx != 2'b11) begin
                        state <= ST_APPLY;
                        idx   <= idx + 2'b01;
                        {b_out, a_out} <= idx + 2'b01;
                    end else if (loop_cnt != LOOP_W'(LOOPS - 1)) begin
                        state    <= ST_APPLY;
                        idx      <= 2'b00;
                        {b_out, a_out} <= 2'b00;
                        loop_cnt <= loop_cnt + LOOP_W'(1);
                    end else begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next_c == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker: three instances cover default, multi-loop
// and saturating-counter configurations against simple gate models.
module tb_gate_bist_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start12 = 1'b0;
    logic mode = 1'b0;

    logic a0, b0, busy0, done0, pass0, o0;
    logic [7:0] err0;
    logic [3:0] fail0;
    logic a1, b1, busy1, done1, pass1, o1;
    logic [7:0] err1;
    logic [3:0] fail1;
    logic a2, b2, busy2, done2, pass2;
    logic [1:0] err2;
    logic [3:0] fail2;

    int unsigned n_vec = 0;
    int unsigned n_mis = 0;

    always #5 clk = ~clk;

    // Gate models: AND (or stuck-at-1) for u0, OR for u1, stuck-at-1 for u2
    assign o0 = mode ? 1'b1 : (a0 & b0);
    assign o1 = a1 | b1;

    gate_bist_checker u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .o_in(o0),
        .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fail0)
    );

    gate_bist_checker #(.LOOPS(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start12), .o_in(o1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1)
    );

    gate_bist_checker #(.ERR_W(2), .LOOPS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start12), .o_in(1'b1),
        .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_vec(fail2)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One u0 run: start edge is edge 0, done expected at edge 16
    task automatic run_u0(input int unsigned exp_err, input int unsigned exp_fail,
                          input bit mid_pulse);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("start_busy", busy0, 1);
        check("start_done_clr", done0, 0);
        check("start_pass_clr", pass0, 0);
        check("start_err_clr", err0, 0);
        check("start_fail_clr", fail0, 0);
        check("start_pattern", {b0, a0}, 0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 6) start0 = mid_pulse;
            if (c == 7) start0 = 1'b0;
            if (c == 4 || c == 8 || c == 12) check("pattern_step", {b0, a0}, c / 4);
            if (c == 3 || c == 7) check("pattern_hold", {b0, a0}, (c - 3) / 4);
            if (c == 15) begin
                check("done_early", done0, 0);
                check("busy_late", busy0, 1);
            end
        end
        check("end_done", done0, 1);
        check("end_busy", busy0, 0);
        check("end_pass", pass0, (exp_err == 0) ? 1 : 0);
        check("end_err", err0, exp_err);
        check("end_fail", fail0, exp_fail);
        check("end_pattern", {b0, a0}, 3);
    endtask

    initial begin
        #3;
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        check("rst_fail", fail0, 0);
        check("rst_pattern", {b0, a0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct AND gate
        mode = 1'b0;
        run_u0(0, 4'b0000, 1'b0);
        tick();
        check("idle_hold_pattern", {b0, a0}, 3);
        check("idle_hold_done", done0, 1);

        // Stuck-at-1 output, restarted from DONE
        mode = 1'b1;
        run_u0(3, 4'b0111, 1'b0);

        // Restart clears the failed result; mid-run start is ignored
        mode = 1'b0;
        run_u0(0, 4'b0000, 1'b1);

        // Reset during SETTLE of pattern 2
        mode = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 9; c++) tick();
        check("pre_rst_pattern", {b0, a0}, 2);
        check("pre_rst_err", err0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy0, 0);
        check("arst_err", err0, 0);
        check("arst_fail", fail0, 0);
        check("arst_pattern", {b0, a0}, 0);
        check("arst_done", done0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 1'b0;
        @(negedge clk);
        run_u0(0, 4'b0000, 1'b0);

        // OR gate vs AND table over 3 loops, and saturating 2-bit counter
        start12 = 1'b1;
        tick();
        start12 = 1'b0;
        for (int c = 1; c <= 48; c++) begin
            tick();
            if (c == 31) check("sat_done_early", done2, 0);
            if (c == 32) begin
                check("sat_done", done2, 1);
                check("sat_err", err2, 3);
                check("sat_fail", fail2, 4'b0111);
                check("sat_pass", pass2, 0);
            end
            if (c == 47) check("loop3_done_early", done1, 0);
        end
        check("loop3_done", done1, 1);
        check("loop3_err", err1, 6);
        check("loop3_fail", fail1, 4'b0110);
        check("loop3_pass", pass1, 0);
        check("loop3_busy", busy1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
